// File: rtl/instrumented_sweep_ctrl.sv
// Sweeps the ring-oscillator tap across adder bits (settle, count, store per bit) into a readback buffer.
// Defining SWEEP_MINMAX_EN adds per-sweep min/max result tracking on registers 6 and 7.
module instrumented_sweep_ctrl #(
    parameter int WIDTH       = 32,
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic             wb_clk_i,
    input  logic             reset_b,
    input  logic             write,
    input  logic [3:0]       reg_sel,
    input  logic [31:0]      data_in,
    output logic [31:0]      data_out,
    input  logic             ring_div,
    output logic             stop_b,
    output logic [WIDTH-1:0] sel_b,
    output logic             busy,
    output logic             done
);
    localparam int          IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [7:0]  MAX_IDX = 8'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COUNT, S_STORE} state_t;

    state_t                 r_state, w_state_next;
    logic [7:0]             r_first, r_last, r_raddr, r_idx;
    logic [31:0]            r_integ, r_timer;
    logic [15:0]            r_settle;
    logic                   r_err, r_done;
    logic [CNT_W-1:0]       r_count;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_ring_prev;
    logic [CNT_W-1:0]       r_mem [WIDTH];

    logic        w_ctrl_wr, w_start_req, w_abort, w_range_ok, w_start_ok;
    logic        w_settle_end, w_count_end, w_edge;
    logic [31:0] w_integ_last, w_rdata;

    assign w_ctrl_wr    = write && (reg_sel == 4'd0);
    assign w_abort      = w_ctrl_wr && data_in[1];
    assign w_start_req  = w_ctrl_wr && data_in[0] && !data_in[1];
    assign w_range_ok   = (r_first <= r_last) && (r_last <= MAX_IDX);
    assign w_start_ok   = (r_state == S_IDLE) && w_start_req && w_range_ok;
    assign w_integ_last = (r_integ == 32'd0) ? 32'd0 : r_integ - 32'd1;
    assign w_settle_end = (r_timer == {16'd0, r_settle});
    assign w_count_end  = (r_timer == w_integ_last);
    assign w_edge       = r_sync[SYNC_STAGES-1] && !r_ring_prev;
    assign w_rdata      = (r_raddr <= MAX_IDX) ? 32'(r_mem[r_raddr[IDX_W-1:0]]) : 32'd0;

    always_ff @(posedge wb_clk_i) begin
        if (!reset_b) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_start_ok)   w_state_next = S_SETTLE;
                S_SETTLE: if (w_settle_end) w_state_next = S_COUNT;
                S_COUNT:  if (w_count_end)  w_state_next = S_STORE;
                S_STORE:  w_state_next = (r_idx == r_last) ? S_IDLE : S_SETTLE;
                default:  w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy   = (r_state != S_IDLE);
        stop_b = (r_state == S_COUNT);
        done   = r_done;
        sel_b  = '1;
        if (r_state != S_IDLE) sel_b = ~({{(WIDTH-1){1'b0}}, 1'b1} << r_idx);
    end

    always_ff @(posedge wb_clk_i) begin
        if (!reset_b) begin
            r_first     <= 8'd0;
            r_last      <= MAX_IDX;
            r_integ     <= 32'd1000;
            r_settle    <= 16'd16;
            r_raddr     <= 8'd0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_idx       <= 8'd0;
            r_timer     <= 32'd0;
            r_count     <= '0;
            r_sync      <= '0;
            r_ring_prev <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], ring_div};
            r_ring_prev <= r_sync[SYNC_STAGES-1];
            if (write && !busy) begin
                case (reg_sel)
                    4'd1:    {r_last, r_first} <= data_in[15:0];
                    4'd2:    r_integ <= data_in;
                    4'd3:    r_settle <= data_in[15:0];
                    default: ;
                endcase
            end
            if (write && reg_sel == 4'd4) r_raddr <= data_in[7:0];
            if (w_start_ok) begin
                r_err  <= 1'b0;
                r_done <= 1'b0;
                r_idx  <= r_first;
            end else if (r_state == S_IDLE && w_start_req && !w_range_ok) begin
                r_err <= 1'b1;
            end
            // The phase timer restarts on every state change so each phase counts from zero.
            if (r_state == S_IDLE || w_state_next != r_state) r_timer <= 32'd0;
            else                                              r_timer <= r_timer + 32'd1;
            if (r_state == S_SETTLE)
                r_count <= '0;
            else if (r_state == S_COUNT && w_edge && r_count != CNT_MAX)
                r_count <= r_count + 1'b1;
            if (r_state == S_STORE && !w_abort) begin
                if (r_idx == r_last) r_done <= 1'b1;
                else                 r_idx  <= r_idx + 8'd1;
            end
        end
    end

    // Result buffer is deliberately left unreset; a store always commits, even alongside an abort.
    always_ff @(posedge wb_clk_i) begin
        if (reset_b && r_state == S_STORE) r_mem[r_idx[IDX_W-1:0]] <= r_count;
    end

`ifdef SWEEP_MINMAX_EN
    logic [23:0] r_min_cnt, r_max_cnt, w_cnt24;
    logic [7:0]  r_min_idx, r_max_idx;
    logic        r_mm_valid;

    assign w_cnt24 = 24'(r_count);

    // Strict comparisons keep the lower index on ties because bits are visited in ascending order.
    always_ff @(posedge wb_clk_i) begin
        if (!reset_b || w_start_ok) begin
            r_min_cnt  <= 24'hFFFFFF;
            r_min_idx  <= 8'd0;
            r_max_cnt  <= 24'd0;
            r_max_idx  <= 8'd0;
            r_mm_valid <= 1'b0;
        end else if (r_state == S_STORE) begin
            r_mm_valid <= 1'b1;
            if (!r_mm_valid || w_cnt24 < r_min_cnt) begin
                r_min_cnt <= w_cnt24;
                r_min_idx <= r_idx;
            end
            if (!r_mm_valid || w_cnt24 > r_max_cnt) begin
                r_max_cnt <= w_cnt24;
                r_max_idx <= r_idx;
            end
        end
    end
`endif

    always_comb begin
        data_out = 32'd0;
        case (reg_sel)
            4'd0:    data_out = {29'd0, r_err, r_done, busy};
            4'd1:    data_out = {16'd0, r_last, r_first};
            4'd2:    data_out = r_integ;
            4'd3:    data_out = {16'd0, r_settle};
            4'd4:    data_out = {24'd0, r_raddr};
            4'd5:    data_out = w_rdata;
`ifdef SWEEP_MINMAX_EN
            4'd6:    data_out = {r_min_idx, r_min_cnt};
            4'd7:    data_out = {r_max_idx, r_max_cnt};
`endif
            default: data_out = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_instrumented_sweep_ctrl.sv
// Directed plus randomized bench for instrumented_sweep_ctrl; expected timing and counts come from a cycle-timeline model.
module tb_instrumented_sweep_ctrl;
    logic        clk, reset_b, write, write8, ring_div;
    logic [3:0]  reg_sel;
    logic [31:0] data_in, data_out, data_out8, sel_b;
    logic [15:0] sel_b8;
    logic        stop_b, busy, done, stop_b8, busy8, done8;

    int n_checks = 0;
    int n_fail   = 0;
    int ring_period = 0;
    int ring_ph = 0;
    int per_tab [0:31];

    instrumented_sweep_ctrl dut (
        .wb_clk_i(clk), .reset_b(reset_b), .write(write), .reg_sel(reg_sel),
        .data_in(data_in), .data_out(data_out), .ring_div(ring_div),
        .stop_b(stop_b), .sel_b(sel_b), .busy(busy), .done(done)
    );

    instrumented_sweep_ctrl #(.WIDTH(16), .CNT_W(8)) dut8 (
        .wb_clk_i(clk), .reset_b(reset_b), .write(write8), .reg_sel(reg_sel),
        .data_in(data_in), .data_out(data_out8), .ring_div(ring_div),
        .stop_b(stop_b8), .sel_b(sel_b8), .busy(busy8), .done(done8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Ring source: one rising edge every ring_period clocks, changed shortly after each rising clock.
    initial begin
        ring_div = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (ring_period < 2) begin
                ring_div = 1'b0;
            end else begin
                if (ring_ph >= ring_period) ring_ph = 0;
                ring_div = (ring_ph < ring_period / 2);
                ring_ph++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs >= exp - 1 && obs <= exp + 1) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d+-1", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        reg_sel = a; data_in = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic wr8(input logic [3:0] a, input logic [31:0] d);
        reg_sel = a; data_in = d; write8 = 1'b1;
        @(negedge clk);
        write8 = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        reg_sel = a;
        #1 d = data_out;
        @(negedge clk);
    endtask

    task automatic rd8(input logic [3:0] a, output logic [31:0] d);
        reg_sel = a;
        #1 d = data_out8;
        @(negedge clk);
    endtask

    task automatic read_result(input int b, output logic [31:0] d);
        wr(4'd4, b);
        rd(4'd5, d);
    endtask

    // Walks the expected timeline from the first cycle after the start write: each bit spends
    // s+1 cycles settling, max(integ,1) counting and one storing; tmax<0 runs to completion.
    task automatic run_timeline(input string tag, input int first, input int nbits,
                                input int s, input int integ, input int tmax);
        int ie, pb, total, last_t, bad, b, ph;
        logic exp_stop;
        ie = (integ == 0) ? 1 : integ;
        pb = s + ie + 2;
        total = nbits * pb;
        last_t = (tmax < 0) ? total : tmax;
        bad = 0;
        for (int t = 0; t <= last_t; t++) begin
            if (t < total) begin
                b = first + t / pb;
                ph = t % pb;
                if (ph == 0) ring_period = per_tab[t / pb];
                exp_stop = (ph >= s + 1) && (ph < s + 1 + ie);
                if (busy !== 1'b1 || done !== 1'b0 || stop_b !== exp_stop) bad++;
                if (ph < s + 1 + ie && sel_b !== ~(32'd1 << b)) bad++;
            end else begin
                if (busy !== 1'b0 || done !== 1'b1 || stop_b !== 1'b0 || sel_b !== 32'hFFFF_FFFF) bad++;
            end
            if (t < last_t) @(negedge clk);
        end
        chk({tag, "_timeline_errs"}, bad, 0);
    endtask

    task automatic do_sweep(input string tag, input int first, input int nbits, input int s, input int integ);
        wr(4'd1, ((first + nbits - 1) << 8) | first);
        wr(4'd3, s);
        wr(4'd2, integ);
        ring_period = per_tab[0];
        repeat (4) @(negedge clk);
        wr(4'd0, 32'd1);
        run_timeline(tag, first, nbits, s, integ, -1);
    endtask

    logic [31:0] v;
    int f, nb, s, ig;

    initial begin
        reset_b = 1'b0; write = 1'b0; write8 = 1'b0; reg_sel = 4'd0; data_in = 32'd0;
        repeat (2) @(negedge clk);
        reset_b = 1'b1;

        chk("rst_stop_b", stop_b, 0);
        chk("rst_sel_b", sel_b, 32'hFFFF_FFFF);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rd(4'd0, v); chk("rst_ctrl", v, 32'd0);
        rd(4'd1, v); chk("rst_cfg", v, 32'h1F00);
        rd(4'd2, v); chk("rst_integ", v, 32'd1000);
        rd(4'd3, v); chk("rst_settle", v, 32'd16);
        rd(4'd4, v); chk("rst_raddr", v, 32'd0);
        rd(4'd8, v); chk("rst_reg8", v, 32'd0);
        rd(4'd15, v); chk("rst_reg15", v, 32'd0);
        rd8(4'd1, v); chk("rst_cfg_w16", v, 32'h0F00);
`ifdef SWEEP_MINMAX_EN
        rd(4'd6, v); chk("rst_min", v, 32'h00FF_FFFF);
        rd(4'd7, v); chk("rst_max", v, 32'd0);
`else
        rd(4'd6, v); chk("rst_reg6", v, 32'd0);
        rd(4'd7, v); chk("rst_reg7", v, 32'd0);
`endif

        // Single bit 5: busy from cycle 1, count cycles 5..104, done in cycle 106.
        per_tab[0] = 10;
        do_sweep("single", 5, 1, 3, 100);
        read_result(5, v); chk_near("single_rdata5", v, 10);
        rd(4'd0, v); chk("single_ctrl", v, 32'd2);

        per_tab[0] = 4; per_tab[1] = 6; per_tab[2] = 8; per_tab[3] = 10;
        do_sweep("sweep", 0, 4, 8, 120);
        for (int k = 0; k < 4; k++) begin
            read_result(k, v);
            chk_near($sformatf("sweep_bit%0d", k), v, 120 / per_tab[k]);
        end

        for (int r = 0; r < 3; r++) begin
            f = $urandom_range(0, 28); nb = $urandom_range(1, 4);
            s = $urandom_range(4, 12); ig = $urandom_range(20, 90);
            for (int k = 0; k < nb; k++) per_tab[k] = 2 * $urandom_range(2, 8);
            do_sweep($sformatf("rand%0d", r), f, nb, s, ig);
            for (int k = 0; k < nb; k++) begin
                read_result(f + k, v);
                chk_near($sformatf("rand%0d_bit%0d", r, f + k), v, ig / per_tab[k]);
            end
        end

        // Top bit with zero integration: one count cycle, at most one edge.
        per_tab[0] = 4;
        do_sweep("integ0", 31, 1, 4, 0);
        read_result(31, v); chk_near("integ0_bit31", v, 0);
        wr(4'd4, 40); rd(4'd5, v); chk("rdata_oob", v, 32'd0);

        wr(4'd1, 32'h0309); wr(4'd0, 32'd1);
        chk("inv_busy", busy, 0);
        rd(4'd0, v); chk("inv_ctrl", v, 32'd6);
        wr(4'd1, 32'h2800); wr(4'd0, 32'd1);
        rd(4'd0, v); chk("inv_last_ctrl", v, 32'd6);
        wr(4'd1, 32'h0100); wr(4'd0, 32'd3);
        chk("start_abort_busy", busy, 0);
        rd(4'd0, v); chk("start_abort_ctrl", v, 32'd6);
        wr(4'd2, 60); wr(4'd3, 4);
        ring_period = 4;
        wr(4'd0, 32'd1);
        chk("valid_busy", busy, 1);
        for (int i = 0; i < 400 && busy; i++) @(negedge clk);
        rd(4'd0, v); chk("valid_ctrl", v, 32'd2);

        // Saturation on the 8-bit-count instance.
        wr8(4'd2, 1000); wr8(4'd1, 32'h0000);
        ring_period = 2;
        repeat (4) @(negedge clk);
        wr8(4'd0, 32'd1);
        for (int i = 0; i < 1200 && !done8; i++) @(negedge clk);
        chk("sat_done", done8, 1);
        wr8(4'd4, 0); rd8(4'd5, v); chk("sat_rdata", v, 32'd255);
        wr8(4'd4, 20); rd8(4'd5, v); chk("sat_rdata_oob", v, 32'd0);

        // Abort during COUNT of bit 2 in a 0..7 sweep, after a locked INTEG write.
        per_tab[0] = 6; per_tab[1] = 5;
        for (int k = 2; k < 8; k++) per_tab[k] = 8;
        wr(4'd1, 32'h0700); wr(4'd3, 4); wr(4'd2, 50);
        ring_period = per_tab[0];
        repeat (4) @(negedge clk);
        wr(4'd0, 32'd1);
        run_timeline("abort", 0, 8, 4, 50, 2 * 56 + 15);
        wr(4'd2, 5);
        wr(4'd0, 32'd2);
        chk("abort_busy", busy, 0);
        chk("abort_stop_b", stop_b, 0);
        chk("abort_sel_b", sel_b, 32'hFFFF_FFFF);
        chk("abort_done", done, 0);
        rd(4'd2, v); chk("abort_integ_locked", v, 32'd50);
        read_result(0, v); chk_near("abort_kept0", v, 50 / 6);
        read_result(1, v); chk_near("abort_kept1", v, 50 / 5);

        wr(4'd0, 32'd1);
        repeat (30) @(negedge clk);
        chk("midrst_busy_before", busy, 1);
        reset_b = 1'b0;
        @(negedge clk);
        reset_b = 1'b1;
        chk("midrst_busy", busy, 0);
        chk("midrst_stop_b", stop_b, 0);
        chk("midrst_sel_b", sel_b, 32'hFFFF_FFFF);
        rd(4'd1, v); chk("midrst_cfg", v, 32'h1F00);
        rd(4'd2, v); chk("midrst_integ", v, 32'd1000);

        per_tab[0] = 6; per_tab[1] = 14; per_tab[2] = 14;
        do_sweep("minmax", 0, 3, 8, 42);
        for (int k = 0; k < 3; k++) begin
            read_result(k, v);
            chk($sformatf("minmax_bit%0d", k), v, 42 / per_tab[k]);
        end
`ifdef SWEEP_MINMAX_EN
        rd(4'd6, v); chk("min_reg", v, 32'h0100_0003);
        rd(4'd7, v); chk("max_reg", v, 32'h0000_0007);
`else
        rd(4'd6, v); chk("reg6_zero", v, 32'd0);
        rd(4'd7, v); chk("reg7_zero", v, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
